// File: rtl/prom_read_cache.sv
// Direct-mapped read cache for 68k program ROM / work RAM fetches.
// Hits are served from local storage; misses issue one 4-word burst fill request.
// Write snooping and a flush input keep the contents coherent with other SDRAM writers.
module prom_read_cache #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned ADDR_W = 19,
    parameter logic [26:0] BASE   = 27'h0200000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [15:0]       cpu_data,
    output logic              cpu_data_rdy,
    output logic              cpu_busy,
    output logic              fill_req,
    output logic [26:0]       fill_addr,
    input  logic              fill_ack,
    input  logic [63:0]       fill_data,
    input  logic              snoop_wr,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              flush,
    output logic [15:0]       hit_count
);

    localparam int unsigned Lines = 2 ** IDX_W;
    localparam int unsigned TagW  = ADDR_W - IDX_W - 2;
    localparam int unsigned LineW = ADDR_W - 2;

    typedef enum logic [1:0] {StIdle, StLookup, StFill, StRespond} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [Lines-1:0]  valid_q;
    logic              poison_q;

    logic [TagW-1:0]   tag_mem  [Lines];
    logic [63:0]       data_mem [Lines];
    logic [TagW-1:0]   rd_tag;
    logic [63:0]       rd_data;

    logic [IDX_W-1:0]  idx_q;
    logic [TagW-1:0]   tag_q;
    logic [LineW-1:0]  line_q;
    logic [1:0]        off_q;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  snoop_idx;
    logic [LineW-1:0]  snoop_line;
    logic              unused_snoop_off;

    logic accept, hit, miss, take;
    logic lookup_hit, poison_now;

    assign idx_q      = addr_q[IDX_W+1:2];
    assign tag_q      = addr_q[ADDR_W-1:IDX_W+2];
    assign line_q     = addr_q[ADDR_W-1:2];
    assign off_q      = addr_q[1:0];
    assign cpu_idx    = cpu_addr[IDX_W+1:2];
    assign snoop_idx  = snoop_addr[IDX_W+1:2];
    assign snoop_line = snoop_addr[ADDR_W-1:2];
    // Snoops act on whole lines, so the word offset is irrelevant.
    assign unused_snoop_off = ^snoop_addr[1:0];

    // The in-flight read sees valid as it was before any same-cycle snoop (old data wins).
    assign lookup_hit = enable && valid_q[idx_q] && (rd_tag == tag_q);
    assign poison_now = flush || (snoop_wr && (snoop_line == line_q));

    function automatic logic [15:0] word_sel(input logic [63:0] d, input logic [1:0] off);
        logic [15:0] w;
        w = d[63:48];
        case (off)
            2'd0: w = d[63:48];
            2'd1: w = d[47:32];
            2'd2: w = d[31:16];
            2'd3: w = d[15:0];
            default: w = d[63:48];
        endcase
        return w;
    endfunction

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        hit     = 1'b0;
        miss    = 1'b0;
        take    = 1'b0;
        case (state_q)
            StIdle: begin
                if (cpu_rd_req && !cpu_busy) begin
                    accept  = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (lookup_hit) begin
                    hit     = 1'b1;
                    state_d = StIdle;
                end else begin
                    miss    = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (fill_ack) begin
                    take    = 1'b1;
                    state_d = StRespond;
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Tag/data RAM: synchronous read on request accept, write on a fill while enabled.
    always_ff @(posedge clk_sys) begin
        if (take && enable) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= fill_data;
        end
        if (accept) begin
            rd_tag  <= tag_mem[cpu_idx];
            rd_data <= data_mem[cpu_idx];
        end
    end

    // Valid bits: allocation first, so a same-cycle snoop or flush always wins.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (take && enable && !poison_q) valid_q[idx_q] <= 1'b1;
            if (snoop_wr)                    valid_q[snoop_idx] <= 1'b0;
            if (flush)                       valid_q <= '0;
        end
    end

    // CPU response, fill request and hit counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            addr_q       <= '0;
            cpu_data     <= '0;
            cpu_data_rdy <= 1'b0;
            cpu_busy     <= 1'b0;
            fill_req     <= 1'b0;
            fill_addr    <= '0;
            hit_count    <= '0;
            poison_q     <= 1'b0;
        end else begin
            cpu_data_rdy <= hit || take;
            if (accept) begin
                addr_q   <= cpu_addr;
                cpu_busy <= 1'b1;
            end else if (cpu_data_rdy) begin
                cpu_busy <= 1'b0;
            end
            if (hit) begin
                cpu_data <= word_sel(rd_data, off_q);
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end
            if (miss) begin
                fill_req  <= 1'b1;
                fill_addr <= BASE + 27'({line_q, 3'b000});
                poison_q  <= 1'b0;
            end
            if (take) begin
                fill_req <= 1'b0;
                cpu_data <= word_sel(fill_data, off_q);
            end
            // A snoop/flush hitting the pending line means the burst may be stale.
            if (state_q == StFill && poison_now) poison_q <= 1'b1;
        end
    end

endmodule
